// File: rtl/ysyx_22040729_div_seq_if.sv
// Issue/result handshake bundle between the EXU and the sequential divider.
// The master side issues operations and consumes results; the divider is the slave.
interface ysyx_22040729_div_seq_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic            in_word;
  logic [XLEN-1:0] in_dividend;
  logic [XLEN-1:0] in_divisor;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  modport master (
    output in_valid, in_op, in_word, in_dividend, in_divisor, flush, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_op, in_word, in_dividend, in_divisor, flush, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/ysyx_22040729_div_seq.sv
// Multi-cycle RISC-V M-extension divider (DIV/DIVU/REM/REMU and W forms):
// one restoring shift-subtract step per cycle, ISA corner cases resolved at issue.
module ysyx_22040729_div_seq #(
  parameter int XLEN = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  ysyx_22040729_div_seq_if.slave bus
);
  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d, res_q, res_d;
  logic            is_rem_q, is_rem_d, word_q, word_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic            in_ready, accept, is_signed, a_sign, b_sign;
  logic            div_zero, overflow, corner, ge;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, corner_raw, corner_res;
  logic [XLEN:0]   sh_rem;
  logic [XLEN-1:0] diff, q_fix, r_fix, sel;

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic w);
    return w ? {{H{v[H-1]}}, v[H-1:0]} : v;
  endfunction

  // Operand preparation and corner-case detection, evaluated against the live issue inputs.
  always_comb begin
    is_signed = ~bus.in_op[0];
    a_ext = bus.in_word ? (is_signed ? {{H{bus.in_dividend[H-1]}}, bus.in_dividend[H-1:0]}
                                     : {{H{1'b0}}, bus.in_dividend[H-1:0]})
                        : bus.in_dividend;
    b_ext = bus.in_word ? (is_signed ? {{H{bus.in_divisor[H-1]}}, bus.in_divisor[H-1:0]}
                                     : {{H{1'b0}}, bus.in_divisor[H-1:0]})
                        : bus.in_divisor;
    a_sign  = is_signed & a_ext[XLEN-1];
    b_sign  = is_signed & b_ext[XLEN-1];
    a_mag   = a_sign ? -a_ext : a_ext;
    b_mag   = b_sign ? -b_ext : b_ext;
    min_val = bus.in_word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    overflow = is_signed & (a_ext == min_val) & (&b_ext);
    corner   = div_zero | overflow;
    if (div_zero) corner_raw = bus.in_op[1] ? a_ext : '1;
    else          corner_raw = bus.in_op[1] ? '0 : a_ext;
    corner_res = word_ext(corner_raw, bus.in_word);
  end

  // One restoring step plus the final sign fix-up, both from registered state.
  always_comb begin
    sh_rem = {rem_q, quo_q[XLEN-1]};
    ge     = (sh_rem >= {1'b0, dsr_q});
    // The remainder after a successful subtract is below the divisor, so the low XLEN bits suffice.
    diff   = sh_rem[XLEN-1:0] - dsr_q;
    q_fix  = q_neg_q ? -quo_q : quo_q;
    r_fix  = r_neg_q ? -rem_q : rem_q;
    sel    = is_rem_q ? r_fix : q_fix;
  end

  // Output process: handshake and status flags decoded from the state register.
  always_comb begin
    in_ready       = (state_q == IDLE) && !bus.flush;
    bus.in_ready   = in_ready;
    bus.out_valid  = (state_q == DONE);
    bus.busy       = (state_q != IDLE);
    bus.out_result = res_q;
  end

  assign accept = bus.in_valid & in_ready;

  // Next-state process.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = corner ? DONE : CALC;
      CALC: if (cnt_q == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // Datapath next values.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    res_d    = res_q;
    is_rem_d = is_rem_q;
    word_d   = word_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    unique case (state_q)
      IDLE: if (accept) begin
        rem_d    = '0;
        // W operands are pre-shifted so that N iterations consume exactly their H bits.
        quo_d    = bus.in_word ? (a_mag << H) : a_mag;
        dsr_d    = b_mag;
        is_rem_d = bus.in_op[1];
        word_d   = bus.in_word;
        q_neg_d  = a_sign ^ b_sign;
        r_neg_d  = a_sign;
        cnt_d    = bus.in_word ? CW'(H) : CW'(XLEN);
        if (corner) res_d = corner_res;
      end
      CALC: begin
        rem_d = ge ? diff : sh_rem[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ge};
        cnt_d = cnt_q - CW'(1);
      end
      FIX:     res_d = word_ext(sel, word_q);
      default: ;
    endcase
  end

  // State register process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      res_q    <= '0;
      is_rem_q <= 1'b0;
      word_q   <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      res_q    <= res_d;
      is_rem_q <= is_rem_d;
      word_q   <= word_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end
endmodule

// File: doc/ysyx_22040729_div_seq.md
Name: ysyx_22040729_div_seq

Overview:
Multi-cycle RISC-V M-extension divide unit for the EXU. It covers DIV/DIVU/REM/REMU and the W variants. The block uses a valid/ready handshake on both the issue and result sides. Internally it sequences one restoring shift-subtract iteration per cycle, and it resolves the ISA corner cases (divide-by-zero, signed overflow) without iterating. Issue and result operands are held in registers; the register file is not touched.

Parameters:
XLEN, 64, operand/result width; must be even, W variants use XLEN/2.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  issue request valid
in_ready  output  1  block can accept an issue (state IDLE and !flush)
in_op  input  2  0=DIV 1=DIVU 2=REM 3=REMU
in_word  input  1  1 = W variant (low XLEN/2 bits, result sign-extended)
in_dividend  input  XLEN  rs1 value
in_divisor  input  XLEN  rs2 value
flush  input  1  synchronous kill of in-flight op (pipeline redirect)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  XLEN  quotient or remainder per in_op
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE, out_valid=0, out_result=0, busy=0, iteration counter=0, all operand registers=0. in_ready=1 after reset release.
- Accept: an issue is accepted on a rising edge with in_valid & in_ready. All operand/op/word fields are latched then; inputs are don't-care afterwards.
- Operand prep (at accept):
  - W: operands are the low XLEN/2 bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed ops: the magnitudes are latched, together with sign flags q_neg = sa^sb and r_neg = sa.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> DONE on accept if divisor==0 or overflow; the result is computed directly:
  - DIV/DIVU by zero: all ones.
  - REM/REMU by zero: dividend.
  - Overflow (DIV, dividend=most-negative, divisor=-1): quotient=dividend, remainder=0.
  - W variants apply the same rules at 32 bits, then sign-extend.
- IDLE -> CALC otherwise. The counter loads N = XLEN (or XLEN/2 if word).
- CALC:
  - Each cycle: shift {rem,quo} left 1; if rem_hi >= divisor, subtract and set the quotient LSB.
  - Decrement the counter; go to FIX when the counter reaches 1 on that edge.
  - Exactly N CALC cycles.
- FIX, one cycle:
  - Apply sign correction (negate quotient if q_neg, negate remainder if r_neg, signed ops only).
  - Select quotient or remainder, and sign-extend bit 31 when word=1. This applies to DIVUW/REMUW too, per ISA.
  - Register into out_result, then go to DONE.
- DONE: out_valid=1 and out_result is stable. On out_ready the state goes to IDLE and out_valid drops the next cycle. Without out_ready it holds indefinitely.
- Latency (accept edge = cycle 0, out_valid first high in cycle L):
  - Normal: L = N+2 (66 for XLEN=64, 34 for word).
  - Corner case: L = 1.
- Throughput: no overlap. in_ready stays low from the accept edge until the cycle after the result handshake, so the next accept is at the earliest 1 cycle after out handshake.
- Flush:
  - Sampled on the clock edge. In any state the block goes to IDLE, out_valid=0 the next cycle, and the result is discarded.
  - in_ready is forced 0 while flush=1, so a same-cycle issue is not accepted.
  - Flush in DONE coincident with out_ready: the result is treated as consumed, and the state goes to IDLE.
- Divisor compare and subtract are XLEN+1 bits wide so no carry is lost. The unsigned dividend 2^XLEN-1 must work.
- Unknown in_op values cannot occur (2-bit fully decoded).

Test Plan:
- DIVU 100/7, XLEN=64 -> out_result=14 in cycle 66 after accept; REMU same operands -> 2.
- DIV -7/2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); REM 7/-2 -> 1.
- DIVU x/0 with x=0x1234 -> all ones at L=1; REMU x/0 -> 0x1234; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, REM -> 0, both at L=1.
- DIVUW 0xFFFF_FFFF_0000_0010 / 2 (word=1) -> low 32 = 0x8, result 0x8 at L=34; DIVUW 0xFFFF_FFFE / 1 -> 0xFFFF_FFFF_FFFF_FFFE (sign-extended).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_result stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle, back-to-back issue accepted.
- Flush in CALC cycle 20 with in_valid=1 the same cycle -> no accept, IDLE next cycle, no out_valid; rst_n pulse mid-CALC -> outputs immediately 0, state IDLE; reissue gives the correct result.
